// File: rtl/counter_ctrl.sv
// Programmable terminal-count timer: one-shot or periodic, with pause, abort,
// restart and a divide-by-2N square-wave output.
module counter_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             q_q, q_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] last_count;

    assign last_count = n_q - WIDTH'(1);

    // Priority: stop > start > pause; rst is applied in the register block.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        mode_d  = mode_q;
        count_d = count_q;
        q_d     = q_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (stop) begin
            state_d = IDLE;
            count_d = '0;
            q_d     = 1'b0;
        end else if (start) begin
            if (period != '0) begin
                n_d     = period;
                mode_d  = auto_reload;
                count_d = '0;
                state_d = RUN;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (count_q == last_count) begin
                        count_d = '0;
                        tick_d  = 1'b1;
                        q_d     = ~q_q;
                        if (!mode_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                // Leaving PAUSE costs one edge; counting resumes on the next.
                PAUSE: begin
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            mode_q  <= 1'b0;
            count_q <= '0;
            q_q     <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            q_q     <= q_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign count     = count_q;
    assign tick      = tick_q;
    assign q         = q_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: a vector table for the main command/count
// flow plus hand sequences for pause, restart, reset and wrap corners.
module tb_counter_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst, start, stop, pause, auto_reload;
    logic [W-1:0] period;
    logic [W-1:0] count;
    logic         tick, q, busy, done, err;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         rst, start, stop, pause, ar;
        logic [W-1:0] per;
        logic [W-1:0] e_count;
        logic         e_tick, e_q, e_busy, e_done, e_err;
    } vec_t;

    vec_t vecs[$];

    counter_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .auto_reload(auto_reload), .period(period), .count(count), .tick(tick),
        .q(q), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic s, input logic sp,
                         input logic pa, input logic ar, input logic [W-1:0] per);
        rst = r; start = s; stop = sp; pause = pa; auto_reload = ar; period = per;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] e_count,
                       input logic e_tick, input logic e_q, input logic e_busy,
                       input logic e_done, input logic e_err);
        logic [W+4:0] act, exp;
        act = {count, tick, q, busy, done, err};
        exp = {e_count, e_tick, e_q, e_busy, e_done, e_err};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual{count,tick,q,busy,done,err}=%0d,%b%b%b%b%b required=%0d,%b%b%b%b%b",
                     name, count, tick, q, busy, done, err,
                     e_count, e_tick, e_q, e_busy, e_done, e_err);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic sp, input logic pa,
                       input logic ar, input logic [W-1:0] per, input logic [W-1:0] c,
                       input logic t, input logic qq, input logic b, input logic d,
                       input logic e);
        vec_t v;
        v.rst = r; v.start = s; v.stop = sp; v.pause = pa; v.ar = ar; v.per = per;
        v.e_count = c; v.e_tick = t; v.e_q = qq; v.e_busy = b; v.e_done = d; v.e_err = e;
        vecs.push_back(v);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);

        //   rst st sp pa ar per | cnt tk q bz dn er
        add(1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 4,     0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 4,     1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 4,     2, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 4,     3, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 4,     0, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 4,     1, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 4,     2, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 4,     3, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 4,     0, 1, 0, 1, 0, 0);
        // period/mode wiggled outside the start cycle: no effect
        add(0, 0, 0, 0, 0, 9,     1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 9,     2, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 9,     3, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 9,     0, 1, 1, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0,     0, 0, 0, 0, 0, 0);
        // one-shot N=3
        add(0, 1, 0, 0, 0, 3,     0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 3,     1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 3,     2, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 3,     0, 1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 3,     0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 3,     0, 0, 1, 0, 0, 0);
        // rejected start in IDLE
        add(0, 1, 0, 0, 1, 0,     0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0,     0, 0, 1, 0, 0, 0);
        // N=1 ticks every cycle
        add(0, 1, 0, 0, 1, 1,     0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 1,     0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 1,     0, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 1,     0, 1, 0, 1, 0, 0);
        // rejected start during RUN holds everything for that edge
        add(0, 1, 0, 0, 1, 0,     0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 1, 0,     0, 1, 1, 1, 0, 0);
        // stop wins over start
        add(0, 1, 1, 0, 1, 5,     0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 5,     0, 0, 0, 0, 0, 0);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].pause,
                  vecs[i].ar, vecs[i].per);
            step();
            chk($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_tick, vecs[i].e_q,
                vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err);
        end

        // Pause at count=2 with N=5: count held for three cycles, tick at edge 8
        drive(1, 0, 0, 0, 0, 0); step();
        drive(0, 1, 0, 0, 1, 5); step();
        chk("pause_start", 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 5);
        step(); step();
        chk("pause_cnt2", 2, 0, 0, 1, 0, 0);
        pause = 1'b1; step();
        chk("pause_e3", 2, 0, 0, 1, 0, 0);
        step();
        chk("pause_e4", 2, 0, 0, 1, 0, 0);
        pause = 1'b0; step();
        chk("pause_e5", 2, 0, 0, 1, 0, 0);
        step();
        chk("pause_e6", 3, 0, 0, 1, 0, 0);
        step();
        chk("pause_e7", 4, 0, 0, 1, 0, 0);
        step();
        chk("pause_e8_tick", 0, 1, 1, 1, 0, 0);

        // Pause on the terminal count suppresses that tick
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("pause_run_c%0d", i), W'(i), 0, 1, 1, 0, 0);
        end
        pause = 1'b1; step();
        chk("pause_at_term", 4, 0, 1, 1, 0, 0);
        pause = 1'b0; step();
        chk("pause_release", 4, 0, 1, 1, 0, 0);
        step();
        chk("pause_late_tick", 0, 1, 0, 1, 0, 0);

        // Restart at count=6 with period=2
        drive(0, 1, 0, 0, 1, 8); step();
        chk("rs_start8", 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 8);
        for (int i = 0; i < 6; i++) step();
        chk("rs_cnt6", 6, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 1, 2); step();
        chk("rs_restart", 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 2); step();
        chk("rs_cnt1", 1, 0, 0, 1, 0, 0);
        step();
        chk("rs_tick", 0, 1, 1, 1, 0, 0);

        // Reset at count=3 in a one-shot run, with start asserted alongside
        drive(0, 1, 0, 0, 0, 5); step();
        drive(0, 0, 0, 0, 0, 5);
        step(); step(); step();
        chk("rst_cnt3", 3, 0, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 1, 7); step();
        chk("rst_mid_run", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0); step();
        chk("rst_after", 0, 0, 0, 0, 0, 0);

        // Full-range period: 254 wraps to 0 with tick
        drive(0, 1, 0, 0, 1, 255); step();
        drive(0, 0, 0, 0, 1, 255);
        begin
            int early_ticks;
            early_ticks = 0;
            for (int i = 0; i < 254; i++) begin
                step();
                if (tick) early_ticks++;
            end
            chk("wrap_cnt254", 254, 0, 0, 1, 0, 0);
            checks++;
            if (early_ticks != 0) begin
                errors++;
                $display("FAIL wrap_early_ticks actual=%0d required=0", early_ticks);
            end
        end
        step();
        chk("wrap_tick", 0, 1, 1, 1, 0, 0);
        step();
        chk("wrap_cnt1", 1, 0, 1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
